// File: rtl/edic_pkg.sv
// Shared definitions for the control unit, RAM wrapper and RAM arbiter.
package edic_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        RUN,
        GRANT,
        ACCESS
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between the CPU and the debug/loader port; the debug
// port is only granted at an instruction boundary and holds the CPU while it owns the RAM.
module ram_arbiter
    import edic_pkg::*;
#(
    parameter int ADDR_W    = edic_pkg::ADDR_W,
    parameter int DATA_W    = edic_pkg::DATA_W,
    parameter int MAX_BURST = 8
) (
    input  logic              i_clk,
    input  logic              i_nReset,
    input  logic [ADDR_W-1:0] i_cpuAddr,
    input  logic              i_cpuWe,
    input  logic [DATA_W-1:0] i_cpuWData,
    input  logic              i_cpuBoundary,
    output logic [DATA_W-1:0] o_cpuRData,
    output logic              o_cpuHold,
    input  logic              i_dbgReq,
    input  logic              i_dbgWe,
    input  logic [ADDR_W-1:0] i_dbgAddr,
    input  logic [DATA_W-1:0] i_dbgWData,
    input  logic              i_dbgHalt,
    output logic              o_dbgAck,
    output logic [DATA_W-1:0] o_dbgRData,
    output logic              o_dbgGranted,
    output logic [ADDR_W-1:0] o_ramAddr,
    output logic              o_ramWe,
    output logic [DATA_W-1:0] o_ramWData,
    input  logic [DATA_W-1:0] i_ramRData
);

    localparam int                CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_dbgRData;

    logic w_isRun;
    logic w_isAccess;

    always_ff @(posedge i_clk) begin
        if (!i_nReset) begin
            r_state    <= RUN;
            r_cnt      <= '0;
            r_dbgRData <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if ((i_dbgReq | i_dbgHalt) & i_cpuBoundary)
                        r_state <= GRANT;
                end
                GRANT: begin
                    if (i_dbgReq & (i_dbgHalt | (r_cnt < CNT_MAX))) begin
                        r_state <= ACCESS;
                    end else if (!i_dbgHalt) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                    end
                end
                ACCESS: begin
                    if (!i_dbgWe)
                        r_dbgRData <= i_ramRData;
                    if (r_cnt != CNT_MAX)
                        r_cnt <= r_cnt + 1'b1;
                    r_state <= GRANT;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign w_isRun    = (r_state == RUN);
    assign w_isAccess = (r_state == ACCESS);

    // Write enable and ack are gated by reset so an access interrupted by reset leaves no trace.
    assign o_cpuHold    = ~w_isRun;
    assign o_dbgGranted = ~w_isRun;
    assign o_dbgAck     = w_isAccess & i_nReset;
    assign o_dbgRData   = r_dbgRData;
    assign o_cpuRData   = i_ramRData;

    assign o_ramAddr  = w_isRun ? i_cpuAddr  : i_dbgAddr;
    assign o_ramWData = w_isRun ? i_cpuWData : i_dbgWData;
    assign o_ramWe    = w_isRun ? i_cpuWe    : (w_isAccess & i_dbgWe & i_nReset);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 4-step CPU model and an asynchronous-read RAM model.
module tb_ram_arbiter;

    logic       clk;
    logic       nReset;
    logic [7:0] cpuAddr;
    logic       cpuWe;
    logic [7:0] cpuWData;
    logic       cpuBoundary;
    logic [7:0] cpuRData;
    logic       cpuHold;
    logic       dbgReq;
    logic       dbgWe;
    logic [7:0] dbgAddr;
    logic [7:0] dbgWData;
    logic       dbgHalt;
    logic       dbgAck;
    logic [7:0] dbgRData;
    logic       dbgGranted;
    logic [7:0] ramAddr;
    logic       ramWe;
    logic [7:0] ramWData;
    logic [7:0] ramRData;

    logic [7:0] mem [256];
    logic [1:0] step;
    int         icount;
    int         n_cmp;
    int         n_bad;
    int         mon_step;
    int         mon_we;

    ram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(8)) dut (
        .i_clk         (clk),
        .i_nReset      (nReset),
        .i_cpuAddr     (cpuAddr),
        .i_cpuWe       (cpuWe),
        .i_cpuWData    (cpuWData),
        .i_cpuBoundary (cpuBoundary),
        .o_cpuRData    (cpuRData),
        .o_cpuHold     (cpuHold),
        .i_dbgReq      (dbgReq),
        .i_dbgWe       (dbgWe),
        .i_dbgAddr     (dbgAddr),
        .i_dbgWData    (dbgWData),
        .i_dbgHalt     (dbgHalt),
        .o_dbgAck      (dbgAck),
        .o_dbgRData    (dbgRData),
        .o_dbgGranted  (dbgGranted),
        .o_ramAddr     (ramAddr),
        .o_ramWe       (ramWe),
        .o_ramWData    (ramWData),
        .i_ramRData    (ramRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: preload then clocked writes, all in one process.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
        forever begin
            @(posedge clk);
            if (ramWe) mem[ramAddr] <= ramWData;
        end
    end
    assign ramRData = mem[ramAddr];

    // CPU: 4-step instructions, step 2 writes the instruction count to 0x82.
    always @(posedge clk) begin
        if (!nReset) begin
            step   <= 2'd0;
            icount <= 0;
        end else if (!cpuHold) begin
            step <= step + 2'd1;
            if (step == 2'd3) icount <= icount + 1;
        end
    end
    assign cpuBoundary = (step == 2'd3);
    assign cpuAddr     = 8'h80 | {6'd0, step};
    assign cpuWe       = (step == 2'd2);
    assign cpuWData    = 8'(icount);

    always @(negedge clk) begin
        if (cpuHold && step != 2'd0) mon_step <= mon_step + 1;
        if (dbgGranted && !dbgAck && ramWe) mon_we <= mon_we + 1;
        if (dbgAck && !dbgWe && ramWe) mon_we <= mon_we + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge outside ACCESS; returns at the negedge after ack.
    task automatic dbg_op(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                          output int lat);
        dbgReq   = 1'b1;
        dbgWe    = we;
        dbgAddr  = addr;
        dbgWData = wd;
        lat      = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (dbgAck) break;
        end
        check("ack_seen", {31'd0, dbgAck}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_step1();
        for (int i = 0; i < 10; i++) begin
            if (step == 2'd1) break;
            @(negedge clk);
        end
        check("wait_step1", {30'd0, step}, 32'd1);
    endtask

    int lat;
    int ic7;

    initial begin
        n_cmp = 0; n_bad = 0; mon_step = 0; mon_we = 0;
        nReset = 1'b0;
        dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 8'h05; dbgWData = 8'h00; dbgHalt = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hold",    {31'd0, cpuHold},    32'd0);
        check("rst_ack",     {31'd0, dbgAck},     32'd0);
        check("rst_rdata",   {24'd0, dbgRData},   32'd0);
        check("rst_granted", {31'd0, dbgGranted}, 32'd0);
        nReset = 1'b1;

        // Request pending from reset: grant only at the first boundary (step 3 edge).
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pre_grant", {31'd0, dbgGranted}, 32'd0);
        end
        @(negedge clk);
        check("grant_at_bnd", {31'd0, dbgGranted}, 32'd1);
        check("hold_at_bnd",  {31'd0, cpuHold},    32'd1);
        check("step_frozen",  {30'd0, step},       32'd0);
        @(negedge clk);
        check("ack1", {31'd0, dbgAck}, 32'd1);
        @(negedge clk);
        check("rd05", {24'd0, dbgRData}, 32'h5F);
        dbgReq = 1'b0;

        // Write 0x3C to 0x10 requested while the CPU is in step 1.
        wait_step1();
        dbg_op(1'b1, 8'h10, 8'h3C, lat);
        dbgReq = 1'b0;
        check("wr_lat", lat, 32'd4);
        check("mem10", {24'd0, mem[8'h10]}, 32'h3C);
        @(negedge clk);
        check("hold_drop", {31'd0, cpuHold}, 32'd0);

        dbg_op(1'b0, 8'h10, 8'h00, lat);
        dbgReq = 1'b0;
        check("rd10", {24'd0, dbgRData}, 32'h3C);

        // Ten writes with req held: 8-access burst, one instruction, then the rest.
        wait_step1();
        ic7 = 0;
        for (int k = 0; k < 10; k++) begin
            dbg_op(1'b1, 8'(8'h40 + k), 8'(8'hA0 + k), lat);
            if (k == 0) check("burst_lat0", lat, 32'd4);
            else if (k == 8) check("burst_lat8", lat, 32'd6);
            else check("burst_lat", lat, 32'd1);
            if (k == 7) ic7 = icount;
            if (k == 8) check("one_instr", icount - ic7, 32'd1);
        end
        dbgReq = 1'b0;
        check("mem47", {24'd0, mem[8'h47]}, 32'hA7);
        check("mem49", {24'd0, mem[8'h49]}, 32'hA9);

        // Halt with no request: granted, idle, no acks.
        dbgHalt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dbgGranted) break;
        end
        repeat (3) @(negedge clk);
        check("halt_granted", {31'd0, dbgGranted}, 32'd1);
        check("halt_noack",   {31'd0, dbgAck},     32'd0);
        for (int k = 0; k < 20; k++) begin
            dbg_op(1'b0, 8'(8'h40 + k % 10), 8'h00, lat);
            check("halt_lat", lat, 32'd1);
            check("halt_rd", {24'd0, dbgRData}, 32'(8'hA0 + k % 10));
        end
        dbgReq  = 1'b0;
        dbgHalt = 1'b0;
        @(negedge clk);
        check("release",      {31'd0, dbgGranted}, 32'd0);
        check("resume_step0", {30'd0, step},       32'd0);
        @(negedge clk);
        check("resume_step1", {30'd0, step},       32'd1);

        // Reset in the middle of a write access: no write, no ack.
        dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 8'h20; dbgWData = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dbgGranted) break;
        end
        @(negedge clk);
        check("in_access", {31'd0, dbgAck}, 32'd1);
        nReset = 1'b0;
        #1;
        check("rst_ack_gate", {31'd0, dbgAck}, 32'd0);
        check("rst_we_gate",  {31'd0, ramWe},  32'd0);
        dbgReq = 1'b0;
        @(negedge clk);
        check("rst_state_run", {31'd0, dbgGranted}, 32'd0);
        check("mem20",         {24'd0, mem[8'h20]}, 32'h7A);
        nReset = 1'b1;
        repeat (2) @(negedge clk);

        check("mon_step_frozen", mon_step, 32'd0);
        check("mon_no_dbg_we",   mon_we,   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port program/data RAM between the CPU control unit and the debug/loader port. The CPU owns the RAM by default. The debug port gets the RAM only at an instruction boundary, while `o_cpuHold` freezes the control unit's step counter. It can also halt the CPU indefinitely for program download or inspection. The block sits between the control unit / register datapath and the RAM macro, and is the only driver of the RAM's address, write-enable and write-data pins.

## Interface
Parameters:
- `ADDR_W`, 8, RAM address width
- `DATA_W`, 8, RAM data width
- `MAX_BURST`, 8, maximum debug accesses per grant when not halted (≥1)

Ports:
- `i_clk`  in  1  clock
- `i_nReset`  in  1  synchronous, active-low reset
- `i_cpuAddr`  in  ADDR_W  CPU RAM address
- `i_cpuWe`  in  1  CPU write enable
- `i_cpuWData`  in  DATA_W  CPU write data
- `i_cpuBoundary`  in  1  high during the last step (step 3) of an instruction
- `o_cpuRData`  out  DATA_W  read data to CPU
- `o_cpuHold`  out  1  freeze the CPU step counter and instruction register
- `i_dbgReq`  in  1  debug access request
- `i_dbgWe`  in  1  debug access is a write
- `i_dbgAddr`  in  ADDR_W  debug address
- `i_dbgWData`  in  DATA_W  debug write data
- `i_dbgHalt`  in  1  keep the CPU halted while high
- `o_dbgAck`  out  1  one-cycle access-complete pulse
- `o_dbgRData`  out  DATA_W  registered debug read data
- `o_dbgGranted`  out  1  debug port owns the RAM
- `o_ramAddr`  out  ADDR_W  RAM address
- `o_ramWe`  out  1  RAM write enable (RAM writes on the clock edge)
- `o_ramWData`  out  DATA_W  RAM write data
- `i_ramRData`  in  DATA_W  RAM asynchronous read data

## Operation
- States: RUN, GRANT, ACCESS.
- RUN (CPU owns the RAM; hold=0):
  - → GRANT on an edge where (`i_dbgReq` | `i_dbgHalt`) & `i_cpuBoundary`.
  - Otherwise stay in RUN, so the debug request waits for the next boundary.
- GRANT (hold=1; RAM muxed to the debug port; `o_ramWe`=0):
  - → ACCESS if `i_dbgReq` & (`i_dbgHalt` | cnt<MAX_BURST).
  - Else → RUN if !`i_dbgHalt`.
  - Else stay in GRANT.
- ACCESS (hold=1):
  - `o_ramWe`=`i_dbgWe` gated by `i_nReset`.
  - `o_dbgAck`=1.
  - On a read, `o_dbgRData` ← `i_ramRData`.
  - cnt saturates at MAX_BURST.
  - → GRANT.
- Burst counter `cnt`:
  - Cleared on every entry to RUN.
  - Ignored while `i_dbgHalt`=1.
- Fairness: after a limited burst, RUN is re-entered with the CPU at step 0. The next boundary is at least one full instruction later.
- Muxes:
  - `o_ramAddr`/`o_ramWData` = CPU inputs in RUN, debug inputs otherwise.
  - `o_ramWe` = `i_cpuWe` in RUN, the ACCESS term above otherwise.
  - `o_cpuRData` = `i_ramRData` always.
- Handshake rules:
  - Requester holds addr/we/wdata stable from `i_dbgReq` rise until `o_dbgAck`.
  - A req still high in the cycle after ack is a new request.
- Simultaneous events:
  - `i_dbgHalt` deasserted mid-ACCESS: the access completes, then GRANT decides.
  - Halt rise with no req: GRANT is held with no accesses.
- Reset: any state → RUN. Reset also clears:
  - hold, ack, granted to 0
  - `o_dbgRData`=0
  - cnt=0
- Reset mid-ACCESS: no RAM write occurs (gated) and no ack is issued.

## Timing
- Grant latency:
  - Boundary edge with req → GRANT.
  - Hold=1 and granted=1 from the next cycle.
  - The CPU's step-3 access completes at the boundary edge, and the CPU freezes at step 0.
- Access latency: req sampled in GRANT → ack in the following cycle (ACCESS).
  - Back-to-back accesses take 2 cycles each.
  - The write commits on the edge ending ACCESS.
  - Read data is valid in `o_dbgRData` the cycle after ack and held until the next read.
- Release: GRANT→RUN edge; hold=0 the next cycle.
- All outputs except the muxes/`o_cpuRData` are Moore or registered. Combinational paths are only the mux and state-decode paths.

## Structure
- Shared package `edic_pkg`:
  - `arb_state_t` enum {RUN, GRANT, ACCESS}
  - `ADDR_W` and `DATA_W` constants (also used by the control unit and RAM wrapper)
- No sub-module. One state register, counter and read-data register, plus the output mux, kept flat in `ram_arbiter`.

## Test plan
- Reset with req=1: hold=0, ack=0, rdata=0 after reset; first grant only at the next `i_cpuBoundary`.
- CPU in step 1 when req for write 0x3C→addr 0x10: no grant until the boundary; then GRANT, ack 2 cycles after the boundary edge; RAM[0x10]=0x3C; hold drops.
- Debug read addr 0x10 after the above: `o_dbgRData`=0x3C; no RAM write during GRANT/ACCESS.
- MAX_BURST=8, req held for 10 writes, halt=0: 8 acks, return to RUN, exactly one 4-step instruction executes, remaining 2 acks after the next boundary.
- Halt=1, 20 reads: 20 acks, CPU step frozen at 0 throughout; halt deasserted → RUN, CPU resumes at step 0.
- Reset asserted during ACCESS of write 0xFF→0x20: RAM[0x20] unchanged, no ack, state RUN.
